// File: rtl/uart_io_bridge_pkg.sv
// rtl/uart_io_bridge_pkg.sv - shared types and constants for the UART debug bus bridge
package uart_io_bridge_pkg;

    localparam int OP_BIT  = 7;
    localparam int RSV_MSB = 6;
    localparam int RSV_LSB = 5;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 16;

    // I/O decoder view of dirport: device select over register select
    localparam int DEV_MSB = 4;
    localparam int DEV_LSB = 2;
    localparam int REG_MSB = 1;
    localparam int REG_LSB = 0;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        GET_HI,
        GET_LO,
        REQ,
        BUS_WR,
        BUS_RD0,
        BUS_RD1,
        SEND_ACK,
        SEND_HI,
        SEND_LO,
        SEND_ERR
    } state_t;

endpackage

// File: rtl/uart_io_bridge_timeout.sv
// rtl/uart_io_bridge_timeout.sv - inter-byte idle counter, expires after TIMEOUT_CYCLES idle cycles
module uart_io_bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expire = en && (count == LAST);

    // Holding at zero while disabled gives the clear-on-entry behaviour for free
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr || !en) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_io_bridge.sv
// rtl/uart_io_bridge.sv - UART byte stream to I/O bus read/write initiator
module uart_io_bridge
    import uart_io_bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE       = ERR_BYTE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic [ADDR_W-1:0]   dirport,
    output logic                we,
    output logic [DATA_W-1:0]   outport,
    input  logic [DATA_W-1:0]   inport,
    output logic                busy
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr;
    logic                op_wr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   rdata;
    logic                in_get;
    logic                expire;
    logic                cmd_ok;

    assign in_get = (state == GET_HI) || (state == GET_LO);
    assign cmd_ok = (rx_data[RSV_MSB:RSV_LSB] == 2'b00);
    assign busy   = (state != IDLE);

    uart_io_bridge_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .resetn (reset),
        .clr    (rx_valid),
        .en     (in_get),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            addr  <= '0;
            op_wr <= 1'b0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && rx_valid && cmd_ok) begin
                addr  <= rx_data[ADDR_W-1:0];
                op_wr <= rx_data[OP_BIT];
            end
            if (state == GET_HI && rx_valid) wdata[15:8] <= rx_data;
            if (state == GET_LO && rx_valid) wdata[7:0]  <= rx_data;
            if (state == BUS_RD1)            rdata       <= inport;
        end
    end

    // Bytes arriving outside IDLE/GET_* fall through every branch and are dropped
    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        bus_req  = 1'b0;
        dirport  = '0;
        we       = 1'b0;
        outport  = '0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (!cmd_ok)                 state_nx = SEND_ERR;
                    else if (rx_data[OP_BIT])    state_nx = GET_HI;
                    else                         state_nx = REQ;
                end
            end
            GET_HI: begin
                if (rx_valid)    state_nx = GET_LO;
                else if (expire) state_nx = SEND_ERR;
            end
            GET_LO: begin
                if (rx_valid)    state_nx = REQ;
                else if (expire) state_nx = SEND_ERR;
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) state_nx = op_wr ? BUS_WR : BUS_RD0;
            end
            BUS_WR: begin
                bus_req  = 1'b1;
                dirport  = addr;
                outport  = wdata;
                we       = 1'b1;
                state_nx = SEND_ACK;
            end
            BUS_RD0: begin
                bus_req  = 1'b1;
                dirport  = addr;
                state_nx = BUS_RD1;
            end
            BUS_RD1: begin
                bus_req  = 1'b1;
                dirport  = addr;
                state_nx = SEND_HI;
            end
            SEND_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ACK_BYTE;
                if (tx_ready) state_nx = IDLE;
            end
            SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = rdata[15:8];
                if (tx_ready) state_nx = SEND_LO;
            end
            SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = rdata[7:0];
                if (tx_ready) state_nx = IDLE;
            end
            SEND_ERR: begin
                tx_valid = 1'b1;
                tx_data  = ERR_BYTE;
                if (tx_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_io_bridge.sv
// tb/tb_uart_io_bridge.sv - self-checking bench for uart_io_bridge
module tb_uart_io_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [4:0]  dirport;
    logic        we;
    logic [15:0] outport;
    logic [15:0] inport;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_io_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .dirport  (dirport),
        .we       (we),
        .outport  (outport),
        .inport   (inport),
        .busy     (busy)
    );

    // Device register file on the bus, plus bus/stream monitors
    logic [15:0] dev_mem [32];
    logic [15:0] ref_mem [32];
    logic        dev_clr = 1'b1;
    int          wr_count = 0;
    int          bus_viol = 0;
    int          stab_viol = 0;
    int          req_cycles = 0;
    logic [7:0]  txq [$];
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [7:0]  pd = 8'h00;

    assign inport = dev_mem[dirport];

    always @(posedge clk) begin
        if (dev_clr) begin
            for (int i = 0; i < 32; i++) dev_mem[i] <= 16'h0000;
        end else if (we) begin
            dev_mem[dirport] <= outport;
            wr_count <= wr_count + 1;
            if (!bus_req) bus_viol <= bus_viol + 1;
        end
    end

    always @(negedge clk) begin
        if (pv && !pr && (!tx_valid || tx_data != pd)) stab_viol <= stab_viol + 1;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (bus_req) req_cycles <= req_cycles + 1;
        pv <= tx_valid;
        pr <= tx_ready;
        pd <= tx_data;
    end

    // Transmitter and bus-arbiter models; grant is never revoked while bus_req is high
    int ready_mode = 0;
    int gnt_mode = 0;
    int gnt_wait = 0;
    initial begin
        tx_ready = 1'b1;
        bus_gnt  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
            if (gnt_mode == 0) begin
                bus_gnt = 1'b1;
            end else if (gnt_mode == 2) begin
                bus_gnt = 1'b0;
            end else if (!bus_req) begin
                bus_gnt  = 1'b0;
                gnt_wait = int'($urandom_range(0, 5));
            end else begin
                if (gnt_wait > 0) gnt_wait--;
                bus_gnt = (gnt_wait == 0);
            end
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic expect_reply(input string name, input int n, input logic [7:0] e0, input logic [7:0] e1);
        int t = 0;
        if (n == 0) repeat (30) tick();
        while (txq.size() < n && t < 300) begin
            tick();
            t++;
        end
        repeat (4) tick();
        chk({name, " reply count"}, txq.size(), n);
        if (n > 0 && txq.size() > 0) chk({name, " byte0"}, txq[0], e0);
        if (n > 1 && txq.size() > 1) chk({name, " byte1"}, txq[1], e1);
        txq.delete();
    endtask

    typedef struct {
        int         nin;
        logic [7:0] b0, b1, b2;
        int         nout;
        logic [7:0] e0, e1;
        int         nwr;
        int         breq;
    } vec_t;

    vec_t vt [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, n, bad;
        logic [7:0]  cmd;
        logic [15:0] d;
        logic [4:0]  a;

        vt[0] = '{3, 8'h80, 8'h12, 8'h34, 1, 8'hA5, 8'h00, 1, 1};
        vt[1] = '{1, 8'h00, 8'h00, 8'h00, 2, 8'h12, 8'h34, 0, 1};
        vt[2] = '{3, 8'h9F, 8'hBE, 8'hEF, 1, 8'hA5, 8'h00, 1, 1};
        vt[3] = '{1, 8'h1F, 8'h00, 8'h00, 2, 8'hBE, 8'hEF, 0, 1};
        vt[4] = '{3, 8'h85, 8'hBE, 8'hEF, 1, 8'hA5, 8'h00, 1, 1};
        vt[5] = '{1, 8'h05, 8'h00, 8'h00, 2, 8'hBE, 8'hEF, 0, 1};
        vt[6] = '{1, 8'h40, 8'h00, 8'h00, 1, 8'hEE, 8'h00, 0, 0};
        vt[7] = '{1, 8'h60, 8'h00, 8'h00, 1, 8'hEE, 8'h00, 0, 0};
        vt[8] = '{1, 8'hC5, 8'h00, 8'h00, 1, 8'hEE, 8'h00, 0, 0};
        vt[9] = '{1, 8'h03, 8'h00, 8'h00, 2, 8'h00, 8'h00, 0, 1};
        for (int i = 0; i < 32; i++) ref_mem[i] = 16'h0000;

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset bus_req", bus_req, 0);
        chk("reset dirport", dirport, 0);
        chk("reset we", we, 0);
        chk("reset outport", outport, 0);
        chk("reset busy", busy, 0);
        dev_clr = 1'b0;
        reset   = 1'b1;
        tick();

        // Write latency: last byte -> bus cycle -> ack
        send_byte(8'h80);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("wr req bus_req", bus_req, 1);
        chk("wr req we", we, 0);
        tick();
        chk("wr bus we", we, 1);
        chk("wr bus dirport", dirport, 5'h00);
        chk("wr bus outport", outport, 16'h1234);
        tick();
        chk("wr ack tx_valid", tx_valid, 1);
        chk("wr ack tx_data", tx_data, 8'hA5);
        expect_reply("wr", 1, 8'hA5, 8'h00);
        chk("wr busy idle", busy, 0);
        ref_mem[0] = 16'h1234;

        for (int i = 0; i < 10; i++) begin
            w0 = wr_count;
            r0 = req_cycles;
            send_byte(vt[i].b0);
            if (vt[i].nin > 1) send_byte(vt[i].b1);
            if (vt[i].nin > 2) send_byte(vt[i].b2);
            expect_reply($sformatf("vec%0d", i), vt[i].nout, vt[i].e0, vt[i].e1);
            chk($sformatf("vec%0d writes", i), wr_count - w0, vt[i].nwr);
            chk($sformatf("vec%0d bus_req seen", i), 32'(req_cycles != r0), vt[i].breq);
            if (vt[i].nwr != 0) ref_mem[vt[i].b0[4:0]] = {vt[i].b1, vt[i].b2};
        end

        // Read latency: C -> RD0 -> RD1 -> SEND_HI
        send_byte(8'h05);
        chk("rd req bus_req", bus_req, 1);
        tick();
        chk("rd0 dirport", dirport, 5'h05);
        chk("rd0 we", we, 0);
        tick();
        chk("rd1 dirport", dirport, 5'h05);
        tick();
        chk("rd hi tx_valid", tx_valid, 1);
        chk("rd hi tx_data", tx_data, 8'hBE);
        expect_reply("rd", 2, 8'hBE, 8'hEF);

        // Back-pressure during a read reply
        ready_mode = 2;
        tick();
        send_byte(8'h05);
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!tx_valid || tx_data != 8'hBE) bad++;
        end
        chk("bp held stable", bad, 0);
        chk("bp nothing sent", txq.size(), 0);
        ready_mode = 0;
        expect_reply("bp", 2, 8'hBE, 8'hEF);

        // Timeout after the first data byte
        w0 = wr_count;
        send_byte(8'h81);
        send_byte(8'h12);
        n = 0;
        while (!tx_valid && n < 100) begin
            tick();
            n++;
        end
        chk("timeout cycles", n, TO);
        chk("timeout tx_data", tx_data, 8'hEE);
        expect_reply("timeout", 1, 8'hEE, 8'h00);
        chk("timeout no write", wr_count - w0, 0);
        send_byte(8'h82);
        send_byte(8'hAA);
        send_byte(8'h55);
        expect_reply("post-timeout wr", 1, 8'hA5, 8'h00);
        ref_mem[2] = 16'hAA55;
        send_byte(8'h02);
        expect_reply("post-timeout rd", 2, 8'hAA, 8'h55);

        // Byte arriving on the expiry cycle wins
        send_byte(8'h81);
        repeat (TO - 1) tick();
        send_byte(8'h77);
        send_byte(8'h88);
        expect_reply("expiry race wr", 1, 8'hA5, 8'h00);
        ref_mem[1] = 16'h7788;
        send_byte(8'h01);
        expect_reply("expiry race rd", 2, 8'h77, 8'h88);

        // Grant withheld, stray byte injected while requesting
        gnt_mode = 2;
        tick();
        w0 = wr_count;
        send_byte(8'h83);
        send_byte(8'h56);
        send_byte(8'h78);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(8'h05);
            else tick();
            if (!bus_req || we) bad++;
        end
        chk("gnt wait held", bad, 0);
        chk("gnt wait no write", wr_count - w0, 0);
        gnt_mode = 0;
        expect_reply("gnt", 1, 8'hA5, 8'h00);
        repeat (20) tick();
        chk("gnt no extra reply", txq.size(), 0);
        chk("gnt one write", wr_count - w0, 1);
        ref_mem[3] = 16'h5678;

        // Reset mid-frame
        w0 = wr_count;
        send_byte(8'h80);
        send_byte(8'h12);
        tick();
        reset = 1'b0;
        tick();
        chk("midreset outputs", {tx_valid, tx_data, bus_req, dirport, we, outport, busy}, 0);
        reset = 1'b1;
        repeat (30) tick();
        chk("midreset no reply", txq.size(), 0);
        chk("midreset no write", wr_count - w0, 0);
        send_byte(8'h00);
        expect_reply("midreset rd", 2, 8'h12, 8'h34);

        // Randomized frames against the frame-level model
        ready_mode = 1;
        gnt_mode   = 1;
        for (int f = 0; f < 40; f++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 7) != 0) cmd[6:5] = 2'b00;
            a = cmd[4:0];
            d = 16'($urandom);
            send_byte(cmd);
            if (cmd[6:5] != 2'b00) begin
                expect_reply($sformatf("rnd%0d err", f), 1, 8'hEE, 8'h00);
            end else if (cmd[7]) begin
                repeat ($urandom_range(0, 8)) tick();
                send_byte(d[15:8]);
                repeat ($urandom_range(0, 8)) tick();
                send_byte(d[7:0]);
                ref_mem[a] = d;
                expect_reply($sformatf("rnd%0d wr", f), 1, 8'hA5, 8'h00);
            end else begin
                d = ref_mem[a];
                expect_reply($sformatf("rnd%0d rd", f), 2, d[15:8], d[7:0]);
            end
        end
        ready_mode = 0;
        gnt_mode   = 0;

        chk("tx stability", stab_viol, 0);
        chk("we without bus_req", bus_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
